// File: rtl/quad_dec_oci_trace_pkg.sv
// Shared types and constants for the OCI data-trace collector.
// Optional feature macro: QUAD_DEC_OCI_TRACE_TS_EN (per-record capture timestamp).
package quad_dec_oci_trace_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } trace_state_e;

  localparam int DEF_LANES  = 3;
  localparam int DEF_LANE_W = 10;
  localparam int DEF_CNT_W  = 4;
  localparam int DEF_DEPTH  = 16;
  localparam int DEF_TS_W   = 32;
  localparam int DROP_W     = 16;

  // Saturating increment for the drop counter.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/quad_dec_oci_trace_fifo.sv
// Synchronous FIFO with a registered head (output) register.
// level counts every stored record, including the one presented on rd_data.
// level_next is the occupancy the FIFO will have after this cycle's push/pop.
module quad_dec_oci_trace_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_ready,
  output logic             rd_valid,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] level_next
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LVL_W-1:0] mem_cnt;
  logic             pop;
  logic             head_load;
  logic             from_mem;
  logic             bypass;
  logic             mem_wr;

  // The head register is refilled whenever it is empty or being popped; an
  // empty backing store lets a push land directly in the head (latency 1).
  assign pop        = rd_valid & rd_ready;
  assign mem_cnt    = level - LVL_W'(rd_valid);
  assign head_load  = ~rd_valid | pop;
  assign from_mem   = head_load & (mem_cnt != '0);
  assign bypass     = head_load & (mem_cnt == '0) & wr_en;
  assign mem_wr     = wr_en & ~bypass;
  assign full       = (level == LVL_W'(DEPTH));
  assign level_next = level + LVL_W'(wr_en) - LVL_W'(pop);

  // Backing store write port.
  // NOTE: the storage array is deliberately not reset; the pointers and level
  // define which entries are meaningful, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy and head register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      level <= level_next;
      if (mem_wr) wr_ptr <= wr_ptr + 1'b1;
      if (from_mem) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
      end else if (bypass) begin
        rd_data <= wr_data;
      end
      if (head_load) rd_valid <= from_mem | bypass;
    end
  end

endmodule

// File: rtl/quad_dec_cpu_oci_trace_collector.sv
// Capture block for the CPU OCI data-trace stream: masks/clamps incoming
// buffers, queues them, drains over valid/ready and performs end-of-test flush.
// Optional feature macro: QUAD_DEC_OCI_TRACE_TS_EN adds a free-running cycle
// counter whose value is stored with each record and shown on out_ts.
module quad_dec_cpu_oci_trace_collector
  import quad_dec_oci_trace_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int LANE_W = DEF_LANE_W,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int TS_W   = DEF_TS_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dct_valid,
  input  logic [LANES*LANE_W-1:0]    dct_buffer,
  input  logic [CNT_W-1:0]           dct_count,
  input  logic                       test_ending,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*LANE_W-1:0]    out_data,
  output logic [CNT_W-1:0]           out_count,
`ifdef QUAD_DEC_OCI_TRACE_TS_EN
  output logic [TS_W-1:0]            out_ts,
`endif
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic                       count_err,
  output logic                       test_has_ended
);

  localparam int BUF_W = LANES * LANE_W;
  localparam int LVL_W = $clog2(DEPTH) + 1;
`ifdef QUAD_DEC_OCI_TRACE_TS_EN
  localparam int REC_W = BUF_W + CNT_W + TS_W;
`else
  localparam int REC_W = BUF_W + CNT_W;
`endif

  trace_state_e     state_q;
  logic             running;
  logic             push_req;
  logic             over_range;
  logic [CNT_W-1:0] clamp_cnt;
  logic [BUF_W-1:0] masked;
  logic             fifo_wr;
  logic             fifo_full;
  logic [REC_W-1:0] wr_rec;
  logic [REC_W-1:0] rd_rec;
  logic [LVL_W-1:0] level_next;

  assign running    = (state_q == RUN);
  assign push_req   = running & dct_valid & (dct_count != '0);
  assign over_range = dct_count > CNT_W'(LANES);
  assign clamp_cnt  = over_range ? CNT_W'(LANES) : dct_count;
  // Full is judged on registered occupancy, so a same-cycle pop never makes room.
  assign fifo_wr    = push_req & ~fifo_full;

  // Zero every lane at or above the (clamped) valid-lane count.
  // NOTE: the whole result is defaulted before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    masked = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(clamp_cnt)) masked[i*LANE_W +: LANE_W] = dct_buffer[i*LANE_W +: LANE_W];
    end
  end

`ifdef QUAD_DEC_OCI_TRACE_TS_EN
  logic [TS_W-1:0] ts_cnt;

  // Free-running capture timestamp, wraps modulo 2^TS_W.
  always_ff @(posedge clk) begin
    if (reset) ts_cnt <= '0;
    else       ts_cnt <= ts_cnt + 1'b1;
  end

  assign wr_rec = {ts_cnt, clamp_cnt, masked};
  assign out_ts = rd_rec[BUF_W+CNT_W +: TS_W];
`else
  assign wr_rec = {clamp_cnt, masked};
`endif

  assign out_data  = rd_rec[BUF_W-1:0];
  assign out_count = rd_rec[BUF_W +: CNT_W];

  quad_dec_oci_trace_fifo #(
    .W     (REC_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr_en      (fifo_wr),
    .wr_data    (wr_rec),
    .rd_ready   (out_ready),
    .rd_valid   (out_valid),
    .rd_data    (rd_rec),
    .full       (fifo_full),
    .level      (fill_level),
    .level_next (level_next)
  );

  // Drop counter and sticky out-of-range count flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt  <= '0;
      count_err <= 1'b0;
    end else begin
      if (push_req && fifo_full) drop_cnt <= sat_inc(drop_cnt);
      if (running && dct_valid && over_range) count_err <= 1'b1;
    end
  end

  // End-of-test state machine. Completion is decided on the FIFO's next
  // occupancy so test_has_ended is registered yet rises the cycle after the
  // final pop (or the cycle after test_ending when nothing is queued).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      test_has_ended <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (test_ending) begin
            if (level_next == '0) begin
              state_q        <= DONE;
              test_has_ended <= 1'b1;
            end else begin
              state_q <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (level_next == '0) begin
            state_q        <= DONE;
            test_has_ended <= 1'b1;
          end
        end
        DONE: begin
          test_has_ended <= 1'b1;
        end
        default: begin
          state_q        <= RUN;
          test_has_ended <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quad_dec_cpu_oci_trace_collector.sv
// Self-checking bench: queue-based reference model compared every cycle,
// plus literal expectations from the directed scenarios.
module tb_quad_dec_cpu_oci_trace_collector;

  localparam int LANES  = 3;
  localparam int LANE_W = 10;
  localparam int CNT_W  = 4;
  localparam int DEPTH  = 16;
  localparam int TS_W   = 4;
  localparam int BUF_W  = LANES * LANE_W;

  logic             clk;
  logic             reset;
  logic             dct_valid;
  logic [BUF_W-1:0] dct_buffer;
  logic [CNT_W-1:0] dct_count;
  logic             test_ending;
  logic             out_valid;
  logic             out_ready;
  logic [BUF_W-1:0] out_data;
  logic [CNT_W-1:0] out_count;
`ifdef QUAD_DEC_OCI_TRACE_TS_EN
  logic [TS_W-1:0]  out_ts;
`endif
  logic [4:0]       fill_level;
  logic [15:0]      drop_cnt;
  logic             count_err;
  logic             test_has_ended;

  quad_dec_cpu_oci_trace_collector #(
    .LANES(LANES), .LANE_W(LANE_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .dct_valid      (dct_valid),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .test_ending    (test_ending),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_count      (out_count),
`ifdef QUAD_DEC_OCI_TRACE_TS_EN
    .out_ts         (out_ts),
`endif
    .fill_level     (fill_level),
    .drop_cnt       (drop_cnt),
    .count_err      (count_err),
    .test_has_ended (test_has_ended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [BUF_W-1:0] data;
    int               cnt;
    int               ts;
  } rec_t;

  rec_t q[$];
  rec_t r;
  int   m_drops;
  bit   m_err, m_flush, m_ended, m_live;
  int   m_ts;
  bit   m_was_full;
  int   m_n;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_drops = 0; m_err = 0; m_flush = 0; m_ended = 0; m_ts = 0;
      m_live  = 1;
    end else if (m_live) begin
      m_was_full = (q.size() >= DEPTH);
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (!m_flush && dct_valid && dct_count != 0) begin
        if (int'(dct_count) > LANES) m_err = 1;
        if (m_was_full) begin
          if (m_drops < 65535) m_drops++;
        end else begin
          m_n    = (int'(dct_count) > LANES) ? LANES : int'(dct_count);
          r.data = BUF_W'(64'(dct_buffer) & ((64'd1 << (m_n * LANE_W)) - 64'd1));
          r.cnt  = m_n;
          r.ts   = m_ts;
          q.push_back(r);
        end
      end
      if (!m_flush && test_ending) m_flush = 1;
      if (m_flush && q.size() == 0) m_ended = 1;
      m_ts = (m_ts + 1) % (1 << TS_W);
    end
  end

  // Single compare process, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("fill_level", 64'(fill_level), 64'(q.size()));
      check("drop_cnt", 64'(drop_cnt), 64'(m_drops));
      check("count_err", 64'(count_err), 64'(m_err));
      check("test_has_ended", 64'(test_has_ended), 64'(m_ended));
      if (q.size() > 0) begin
        check("out_data", 64'(out_data), 64'(q[0].data));
        check("out_count", 64'(out_count), 64'(q[0].cnt));
`ifdef QUAD_DEC_OCI_TRACE_TS_EN
        check("out_ts", 64'(out_ts), 64'(q[0].ts));
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; dct_valid = 1'b0; test_ending = 1'b0; out_ready = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic push(input int cnt, input logic [BUF_W-1:0] d);
    dct_valid = 1'b1; dct_count = CNT_W'(cnt); dct_buffer = d;
    step();
    dct_valid = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_data"}, 64'(out_data), 64'd0);
    check({tag, "_out_count"}, 64'(out_count), 64'd0);
    check({tag, "_fill_level"}, 64'(fill_level), 64'd0);
    check({tag, "_drop_cnt"}, 64'(drop_cnt), 64'd0);
    check({tag, "_count_err"}, 64'(count_err), 64'd0);
    check({tag, "_test_has_ended"}, 64'(test_has_ended), 64'd0);
`ifdef QUAD_DEC_OCI_TRACE_TS_EN
    check({tag, "_out_ts"}, 64'(out_ts), 64'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pops;
    int budget;
    reset = 1'b1; dct_valid = 1'b0; dct_buffer = '0; dct_count = '0;
    test_ending = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_vals("reset");

    // Single push: lanes 0..1 kept, lane 2 zeroed.
    push(2, 30'h3FFFFFFF);
    check("single_valid", 64'(out_valid), 64'd1);
    check("single_count", 64'(out_count), 64'd2);
    check("single_data", 64'(out_data), 64'h000FFFFF);
    check("single_fill", 64'(fill_level), 64'd1);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    check("single_drained", 64'(fill_level), 64'd0);

    // Overflow: 20 pushes, 16 kept, 4 dropped, drained in order.
    for (int i = 0; i < 20; i++) push(3, BUF_W'(i + 1));
    check("ovf_fill", 64'(fill_level), 64'd16);
    check("ovf_drop", 64'(drop_cnt), 64'd4);
    check("ovf_head", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    repeat (15) step();
    check("ovf_last", 64'(out_data), 64'd16);
    step();
    out_ready = 1'b0;
    check("ovf_empty", 64'(fill_level), 64'd0);

    // Zero and out-of-range counts.
    do_reset();
    push(0, 30'h12345678);
    check("zero_not_stored", 64'(fill_level), 64'd0);
    check("zero_no_drop", 64'(drop_cnt), 64'd0);
    push(5, 30'h3FFFFFFF);
    check("oor_count", 64'(out_count), 64'd3);
    check("oor_data", 64'(out_data), 64'h3FFFFFFF);
    check("oor_err", 64'(count_err), 64'd1);

    // Randomised traffic with varying back-pressure.
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 150; c++) begin
        dct_valid  = ($urandom_range(0, 3) != 0);
        dct_count  = CNT_W'($urandom_range(0, 7));
        dct_buffer = BUF_W'($urandom);
        out_ready  = ($urandom_range(0, 7) < ph * 2 + 1);
        step();
      end
    end
    dct_valid = 1'b0;

    // Reset mid-run with 5 queued and 2 drops.
    do_reset();
    for (int i = 0; i < 18; i++) push(1, BUF_W'(i + 100));
    out_ready = 1'b1; repeat (11) step(); out_ready = 1'b0;
    check("mid_fill", 64'(fill_level), 64'd5);
    check("mid_drop", 64'(drop_cnt), 64'd2);
    do_reset();
    check_reset_vals("mid_reset");
    push(1, 30'h3FFFFC05);
    check("mid_latency_valid", 64'(out_valid), 64'd1);
    check("mid_latency_data", 64'(out_data), 64'h5);

    // Flush: 3 queued, 4th pushed with test_ending, later pushes ignored.
    do_reset();
    for (int i = 0; i < 3; i++) push(3, BUF_W'(i + 7));
    test_ending = 1'b1;
    push(3, BUF_W'(10));
    for (int i = 0; i < 3; i++) push(3, BUF_W'(i + 50));
    check("flush_fill", 64'(fill_level), 64'd4);
    check("flush_no_drop", 64'(drop_cnt), 64'd0);
    out_ready = 1'b1;
    pops = 0;
    budget = 0;
    while (!test_has_ended && budget < 40) begin
      dct_valid = $urandom_range(0, 1) != 0;
      dct_count = 4'd3;
      if (out_valid && out_ready) pops++;
      step();
      budget++;
    end
    dct_valid = 1'b0;
    check("flush_pops", 64'(pops), 64'd4);
    check("flush_ended", 64'(test_has_ended), 64'd1);
    test_ending = 1'b0;
    repeat (3) step();
    check("flush_ended_sticky", 64'(test_has_ended), 64'd1);

    // Empty flush: ends one cycle after test_ending.
    do_reset();
    test_ending = 1'b1; step(); test_ending = 1'b0;
    check("empty_flush_ended", 64'(test_has_ended), 64'd1);

`ifdef QUAD_DEC_OCI_TRACE_TS_EN
    // Timestamp wrap: pushes at cycles 3 and 19 both carry ts 3.
    do_reset();
    repeat (3) step();
    push(1, BUF_W'(1));
    check("ts_first", 64'(out_ts), 64'd3);
    out_ready = 1'b1;
    repeat (15) step();
    push(1, BUF_W'(2));
    check("ts_wrap", 64'(out_ts), 64'd3);
    out_ready = 1'b0;
`endif

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quad_dec_cpu_oci_trace_collector.md
# quad_dec_cpu_oci_trace_collector

Parametrised capture block for the CPU on-chip-instrumentation (OCI) data-trace stream in simulation and debug builds. Accepts packed trace buffers (`dct_buffer` plus valid-lane count `dct_count`) and stores each non-empty buffer as one record in an internal FIFO. Drains records over a valid/ready port and counts drops on overflow. Performs a controlled end-of-test flush: `test_ending` stops capture, and `test_has_ended` asserts once every stored record has been drained.

## Interface
Parameters:
- `LANES`, 3: trace lanes per buffer
- `LANE_W`, 10: bits per lane; buffer width is `LANES*LANE_W`, 30 by default
- `CNT_W`, 4: width of count fields; must satisfy `2^CNT_W > LANES`
- `DEPTH`, 16: FIFO entries; power of two, at least 2
- `TS_W`, 32: timestamp width; used only with the timestamp feature

Ports:
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `dct_valid`  in  1  buffer strobe
- `dct_buffer`  in  `LANES*LANE_W`  packed lanes; lane 0 is in the LSBs
- `dct_count`  in  `CNT_W`  number of valid lanes, 0..`LANES`
- `test_ending`  in  1  level; request end-of-test flush
- `out_valid`  out  1  record available
- `out_ready`  in  1  consumer accepts record
- `out_data`  out  `LANES*LANE_W`  record lanes; lanes at or above `out_count` read 0
- `out_count`  out  `CNT_W`  valid lanes in record
- `out_ts`  out  `TS_W`  capture timestamp; present only with `QUAD_DEC_OCI_TRACE_TS_EN`
- `fill_level`  out  `$clog2(DEPTH)+1`  FIFO occupancy
- `drop_cnt`  out  16  saturating count of records dropped on overflow
- `count_err`  out  1  sticky; set when a buffer arrived with `dct_count > LANES`
- `test_has_ended`  out  1  flush complete

## Operation
- States:
  - `RUN` is the reset state.
  - `FLUSH`.
  - `DONE`.
- Push condition: state `RUN`, `dct_valid=1` and `dct_count!=0`.
  - Not full: the record is written.
  - Full: the record is dropped and `drop_cnt` increments, saturating at 0xFFFF.
  - A pop in the same cycle does not free space for the push; full is judged on the registered occupancy.
- Count range: if `dct_count > LANES`, the stored count is `LANES`, all lanes are kept, and `count_err` is set.
- Lane masking: lanes at index at or above the count are zeroed when the record is written.
- Pop: `out_valid && out_ready`. `out_data` and `out_count` hold stable while `out_valid=1` and `out_ready=0`.
- `RUN` to `FLUSH`: first cycle in which `test_ending=1`. A buffer presented in that same cycle is still captured.
- In `FLUSH`:
  - `dct_valid` is ignored and not counted as a drop.
  - Draining continues.
- `FLUSH` to `DONE`: when `fill_level==0` and `out_valid==0`.
- `DONE`:
  - Terminal until reset.
  - `test_has_ended=1`.
  - Deasserting `test_ending` has no effect.
- Reset in any state:
  - Discards all contents.
  - Returns to `RUN`.

## Timing
- Reset values:
  - `out_valid=0`, `out_data=0`, `out_count=0`, `out_ts=0`
  - `fill_level=0`, `drop_cnt=0`, `count_err=0`, `test_has_ended=0`
- Latency: a push into an empty FIFO in cycle N gives `out_valid=1` in cycle N+1. Outputs are registered.
- Throughput: one push and one pop per cycle, sustained.
- `fill_level` updates the cycle after a push or pop. A simultaneous push and pop leaves it unchanged.
- `test_has_ended` rises the cycle after the final pop when the FIFO is non-empty at flush. With an empty FIFO it rises one cycle after `test_ending` is seen.
- `count_err` and the `drop_cnt` increment are visible the cycle after the offending strobe.

## Configuration
- `QUAD_DEC_OCI_TRACE_TS_EN` defined:
  - A `TS_W`-bit free-running cycle counter is added. It is cleared by reset and wraps modulo 2^`TS_W`.
  - The counter value is stored with each record and appears on `out_ts`.
- Not defined:
  - No counter is built.
  - No `out_ts` port exists.
  - FIFO width is `LANES*LANE_W+CNT_W`.

## Structure
- Package `quad_dec_oci_trace_pkg`:
  - State enum (`RUN`, `FLUSH`, `DONE`).
  - Default parameter constants.
  - `DROP_W=16`.
- Sub-module `quad_dec_oci_trace_fifo`: synchronous FIFO with registered output, parametrised width and depth.
- Top level contains:
  - State machine.
  - Masking and count clamp.
  - Drop counter and error flag.
  - Timestamp counter.

## Test plan
- Single push, default parameters:
  - Stimulus: `dct_count=2`, `dct_buffer=0x3FFFFFFF`.
  - Response: next cycle `out_valid=1`, `out_count=2`, `out_data=0x000FFFFF`, `fill_level=1`.
- Overflow:
  - Stimulus: `out_ready=0`, 20 consecutive pushes with `DEPTH=16`.
  - Response: `fill_level=16`, `drop_cnt=4`; draining returns the first 16 records in order.
- Zero and out-of-range counts:
  - Stimulus: `dct_count=0`, then `dct_count=5` with `LANES=3`.
  - Response: the first is not stored and `drop_cnt` is unchanged; the second is stored with `out_count=3` and `count_err=1`.
- Flush:
  - Stimulus: 3 records queued, `test_ending=1` in the same cycle as a fourth push, further pushes afterwards.
  - Response: exactly 4 records drain; `test_has_ended` rises the cycle after the 4th pop and stays high after `test_ending=0`.
- Reset mid-run:
  - Stimulus: 5 records queued, `drop_cnt=2`, then assert `reset` for 1 cycle.
  - Response: all outputs return to their reset values; the next push has latency 1.
- Timestamp, with `QUAD_DEC_OCI_TRACE_TS_EN` and `TS_W=4`:
  - Stimulus: pushes at cycles 3 and 19 after reset release.
  - Response: `out_ts=3`, then `out_ts=3` again, because the counter wraps.
